// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, command encodings and FSM states for bus_slave_mem
package bus_pkg;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_t;
endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM, read-before-write, no reset
module sp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - crossbar slave memory with one-shot accept and fixed read latency
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cmd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic              resp_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       rd_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);

  if (RD_LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("bus_slave_mem: RD_LAT must be >= 1 and DEPTH a power of two >= 2");
  end

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rearm_q, rearm_d;

  logic              accept;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  // Upper address bits alias onto the same words by design.
  assign unused_addr_bits = ^addr_i[ADDR_W-1:AW];

  assign accept = (state_q == IDLE) && req_i && rearm_q;
  // Write data is committed at the accept edge, so only the address needs holding.
  assign ram_we   = accept && (cmd_i == CMD_WRITE) && !rst_i;
  assign ram_addr = (state_q == IDLE) ? addr_i[AW-1:0] : addr_q;

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    resp_d   = 1'b0;
    rdata_d  = rdata_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    rearm_d  = rearm_q;

    if (!req_i) begin
      rearm_d = 1'b1;
    end else if (accept) begin
      rearm_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = addr_i[AW-1:0];
          ack_d  = 1'b1;
          if (cmd_i == CMD_WRITE) begin
            state_d = WR_ACK;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      WR_ACK: begin
        ack_d    = 1'b0;
        wr_cnt_d = wr_cnt_q + 16'd1;
        state_d  = IDLE;
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          resp_d  = 1'b1;
          rdata_d = ram_rdata;
          state_d = RD_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RD_RESP: begin
        ack_d    = 1'b0;
        rd_cnt_d = rd_cnt_q + 16'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      rearm_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      rearm_q  <= rearm_d;
    end
  end

  sp_ram #(
    .AW (AW),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_i),
    .rdata_o (ram_rdata)
  );

  assign ack_o    = ack_q;
  assign resp_o   = resp_q;
  assign rdata_o  = rdata_q;
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
endmodule

// File: tb/tb_bus_slave_mem.sv
// tb/tb_bus_slave_mem.sv - directed self-checking bench for bus_slave_mem
module tb_bus_slave_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [30:0] addr = '0;
  logic        cmd = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack_o, resp_o;
  logic [31:0] rdata_o;
  logic [15:0] wr_cnt_o, rd_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_slave_mem #(.DEPTH(256), .RD_LAT(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .addr_i   (addr),
    .cmd_i    (cmd),
    .wdata_i  (wdata),
    .ack_o    (ack_o),
    .resp_o   (resp_o),
    .rdata_o  (rdata_o),
    .wr_cnt_o (wr_cnt_o),
    .rd_cnt_o (rd_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [30:0] a, input logic [31:0] d,
                           output int ack_len, output logic ack_first, output logic resp_seen);
    req = 1'b1; cmd = 1'b1; addr = a; wdata = d;
    ack_len = 0; ack_first = 1'b0; resp_seen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) begin
        ack_first = ack_o;
        req = 1'b0;
      end
      if (ack_o) ack_len++;
      if (resp_o) resp_seen = 1'b1;
    end
  endtask

  task automatic bus_read(input logic [30:0] a, output int rise, output int resp_at,
                          output int fall, output int resp_len, output logic [31:0] data);
    req = 1'b1; cmd = 1'b0; addr = a;
    rise = 0; resp_at = 0; fall = 0; resp_len = 0; data = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) req = 1'b0;
      if (ack_o && rise == 0) rise = i;
      if (!ack_o && rise != 0 && fall == 0) fall = i;
      if (resp_o) begin
        resp_len++;
        if (resp_at == 0) begin
          resp_at = i;
          data = rdata_o;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks += 5;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack_o); end
    if (resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", resp_o); end
    if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    if (wr_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_wr_cnt got %0d want 0", wr_cnt_o); end
    if (rd_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_rd_cnt got %0d want 0", rd_cnt_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int n; logic first, rs;
    bus_write(31'h10, 32'hA5A5_0001, n, first, rs);
    checks += 4;
    if (first !== 1'b1) begin errors++; $display("FAIL write_ack_at_accept got %b want 1", first); end
    if (n != 1) begin errors++; $display("FAIL write_ack_len got %0d want 1", n); end
    if (rs !== 1'b0) begin errors++; $display("FAIL write_no_resp got %b want 0", rs); end
    if (wr_cnt_o !== 16'd1) begin errors++; $display("FAIL write_wr_cnt got %0d want 1", wr_cnt_o); end
  endtask

  task automatic test_read();
    int r, p, f, l; logic [31:0] d;
    bus_read(31'h10, r, p, f, l, d);
    checks += 7;
    if (r != 1) begin errors++; $display("FAIL read_ack_rise got %0d want 1", r); end
    if (p != 5) begin errors++; $display("FAIL read_resp_cycle got %0d want 5", p); end
    if (f != 6) begin errors++; $display("FAIL read_fall_together got %0d want 6", f); end
    if (l != 1) begin errors++; $display("FAIL read_resp_len got %0d want 1", l); end
    if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL read_data got %h want a5a50001", d); end
    if (rd_cnt_o !== 16'd1) begin errors++; $display("FAIL read_rd_cnt got %0d want 1", rd_cnt_o); end
    if (rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL read_data_hold got %h want a5a50001", rdata_o); end
  endtask

  task automatic test_alias();
    int n, r, p, f, l; logic first, rs; logic [31:0] d;
    bus_write(31'h110, 32'h1234_5678, n, first, rs);
    bus_read(31'h10, r, p, f, l, d);
    checks += 3;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL alias_data got %h want 12345678", d); end
    if (wr_cnt_o !== 16'd2) begin errors++; $display("FAIL alias_wr_cnt got %0d want 2", wr_cnt_o); end
    if (rd_cnt_o !== 16'd2) begin errors++; $display("FAIL alias_rd_cnt got %0d want 2", rd_cnt_o); end
  endtask

  task automatic test_hold_req();
    int n, r, p, f, l; logic [31:0] d; logic prev;
    req = 1'b1; cmd = 1'b1; addr = 31'h20; wdata = 32'hCAFE_0020;
    n = 0; prev = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ack_o && !prev) n++;
      prev = ack_o;
      if (i == 1) begin
        addr = 31'h20; wdata = 32'h0BAD_0BAD; cmd = 1'b0;
      end
    end
    req = 1'b0;
    tick();
    checks += 2;
    if (n != 1) begin errors++; $display("FAIL hold_ack_pulses got %0d want 1", n); end
    if (wr_cnt_o !== 16'd3) begin errors++; $display("FAIL hold_wr_cnt got %0d want 3", wr_cnt_o); end
    bus_read(31'h20, r, p, f, l, d);
    checks += 1;
    if (d !== 32'hCAFE_0020) begin errors++; $display("FAIL hold_ignored_change got %h want cafe0020", d); end
  endtask

  task automatic test_reset_collision();
    int n, r, p, f, l; logic first, rs; logic [31:0] d;
    bus_write(31'h30, 32'h1111_1111, n, first, rs);
    rst = 1'b1; req = 1'b1; cmd = 1'b1; addr = 31'h30; wdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; req = 1'b0;
    checks += 2;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL collide_ack got %b want 0", ack_o); end
    if (wr_cnt_o !== 16'd0) begin errors++; $display("FAIL collide_wr_cnt got %0d want 0", wr_cnt_o); end
    tick();
    bus_read(31'h30, r, p, f, l, d);
    checks += 1;
    if (d !== 32'h1111_1111) begin errors++; $display("FAIL collide_ram_kept got %h want 11111111", d); end
  endtask

  task automatic test_reset_mid_read();
    int r, p, f, l, resp_seen; logic [31:0] d;
    req = 1'b1; cmd = 1'b0; addr = 31'h10;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b want 0", ack_o); end
    if (rdata_o !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h want 0", rdata_o); end
    if (rd_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_rd_cnt got %0d want 0", rd_cnt_o); end
    resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_o) resp_seen++;
    end
    checks += 2;
    if (resp_seen != 0) begin errors++; $display("FAIL midrst_no_resp got %0d want 0", resp_seen); end
    if (rd_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_rd_cnt_after got %0d want 0", rd_cnt_o); end
    bus_read(31'h10, r, p, f, l, d);
    checks += 2;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL midrst_ram_kept got %h want 12345678", d); end
    if (rd_cnt_o !== 16'd1) begin errors++; $display("FAIL midrst_later_rd_cnt got %0d want 1", rd_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [30:0] a [20];
    logic [31:0] v [20];
    int n, r, p, f, l; logic first, rs; logic [31:0] d;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      a[i] = {23'($urandom), 8'(i * 12 + $urandom_range(0, 11))};
      v[i] = $urandom;
      bus_write(a[i], v[i], n, first, rs);
    end
    for (int i = 0; i < 20; i++) begin
      bus_read(a[i], r, p, f, l, d);
      checks++;
      if (d !== v[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d] addr %h got %h want %h", i, a[i], d, v[i]);
      end
    end
    checks += 2;
    if (wr_cnt_o !== 16'd20) begin errors++; $display("FAIL b2b_wr_cnt got %0d want 20", wr_cnt_o); end
    if (rd_cnt_o !== 16'd20) begin errors++; $display("FAIL b2b_rd_cnt got %0d want 20", rd_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alias();
    test_hold_req();
    test_reset_collision();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
